// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and types for the ALU issue slice.
// Contents:
//   t_alu          - operation code driven to the external ALU
//   t_issue_state  - issue controller states (IDLE, EXEC, WB)
//   OP_REG/OP_IMM  - major opcodes for R-type and I-type integer ops
//   F3_/F7_        - funct3/funct7 values that select ADD and SUB
//   reg_in_range   - checks a register index against the configured file size
package riscv_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1
  } t_alu;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } t_issue_state;

  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // RV32E only has 16 registers, so indices 16..31 must be rejected there.
  function automatic logic reg_in_range(input logic [4:0] idx, input int unsigned num_regs);
    return 32'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one
// synchronous write port. x0 always reads zero and ignores writes.
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset (clears all)
//   raddr1_i, raddr2_i  - read indices
//   rdata1_o, rdata2_o  - read data, combinational
//   we_i, waddr_i, wdata_i - write enable, index, data (applied on clk_i rise)
module regfile_2r1w #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  localparam int AW = $clog2(NUM_REGS);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // Indices are truncated to the file size; the issue logic never lets an
  // out-of-range index reach a legal instruction.
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i[AW-1:0]];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i[AW-1:0]];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i[AW-1:0]] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: 32'd0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Single-issue front end for an external ADD/SUB ALU. Decodes one RV32
// instruction at a time, reads operands, hands them to the ALU, and
// writes the ALU result back three cycles after acceptance.
// Ports:
//   clk_i, rst_i             - clock, synchronous active-high reset
//   instr_i, instr_valid_i   - instruction word and its valid strobe
//   instr_ready_o            - high in IDLE when not in reset
//   op_o, src1_o, src2_o     - registered ALU operation and operands
//   result_i                 - combinational ALU result
//   wb_valid_o, wb_rd_o, wb_data_o - write-back pulse, index and data
//   illegal_o                - one-cycle pulse after a rejected instruction
// Configuration macro:
//   ALU_ISSUE_ADDI_EN - when defined, ADDI is decoded with a sign-extended
//                       immediate; otherwise ADDI is rejected as illegal.
module alu_issue
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output t_alu        op_o,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  input  logic [31:0] result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        illegal_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] rs1_data, rs2_data;

  logic        accept, dec_legal;
  t_alu        dec_op;
  logic [31:0] dec_src2;

  t_issue_state state_q, state_d;
  t_alu         op_q, op_d;
  logic [31:0]  src1_q, src1_d, src2_q, src2_d;
  logic [4:0]   rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [31:0]  wb_data_q, wb_data_d;
  logic         wb_valid_q, wb_valid_d, illegal_q, illegal_d;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign instr_ready_o = (state_q == IDLE) && !rst_i;
  assign accept        = instr_valid_i && instr_ready_o;

  // The register file is written while in WB, so an instruction accepted
  // the following cycle already reads the new value.
  regfile_2r1w #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .we_i     (state_q == WB),
    .waddr_i  (wb_rd_q),
    .wdata_i  (wb_data_q)
  );

`ifdef ALU_ISSUE_ADDI_EN
  logic [31:0] imm;
  assign imm = {{20{instr_i[31]}}, instr_i[31:20]};
`endif

  // Decode; rs2 is range-checked only for R-type since ADDI reuses those
  // bits as immediate.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_src2  = rs2_data;
    if (opcode == OP_REG && funct3 == F3_ADD_SUB && funct7 == F7_ADD) begin
      dec_legal = 1'b1;
    end else if (opcode == OP_REG && funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
      dec_legal = 1'b1;
      dec_op    = ALU_SUB;
    end
`ifdef ALU_ISSUE_ADDI_EN
    else if (opcode == OP_IMM && funct3 == F3_ADD_SUB) begin
      dec_legal = 1'b1;
      dec_src2  = imm;
    end
`endif
    if (!reg_in_range(rd, NUM_REGS) || !reg_in_range(rs1, NUM_REGS)) begin
      dec_legal = 1'b0;
    end
    if (opcode == OP_REG && !reg_in_range(rs2, NUM_REGS)) begin
      dec_legal = 1'b0;
    end
  end

  // Issue sequencing: IDLE accepts, EXEC waits for the ALU, WB retires.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            state_d = EXEC;
            op_d    = dec_op;
            src1_d  = rs1_data;
            src2_d  = dec_src2;
            rd_d    = rd;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        state_d    = WB;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = result_i;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= ALU_ADD;
      src1_q     <= 32'd0;
      src2_q     <= 32'd0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign op_o       = op_q;
  assign src1_o     = src1_q;
  assign src2_o     = src2_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue. A behavioural ADD/SUB ALU closes the loop;
// it can be overridden with a fixed value so registers can be seeded in
// either build. A second instance with NUM_REGS=16 shares the instruction
// bus to exercise the RV32E index range check.
module tb_alu_issue;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        ovr_en;
  logic [31:0] ovr_val;

  logic        ready32, wb_valid32, illegal32;
  t_alu        op32;
  logic [31:0] src1_32, src2_32, result32, wb_data32;
  logic [4:0]  wb_rd32;

  logic        ready16, wb_valid16, illegal16;
  t_alu        op16;
  logic [31:0] src1_16, src2_16, result16, wb_data16;
  logic [4:0]  wb_rd16;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  alu_issue #(.NUM_REGS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(ready32), .op_o(op32), .src1_o(src1_32), .src2_o(src2_32),
    .result_i(result32), .wb_valid_o(wb_valid32), .wb_rd_o(wb_rd32),
    .wb_data_o(wb_data32), .illegal_o(illegal32)
  );

  alu_issue #(.NUM_REGS(16)) dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(ready16), .op_o(op16), .src1_o(src1_16), .src2_o(src2_16),
    .result_i(result16), .wb_valid_o(wb_valid16), .wb_rd_o(wb_rd16),
    .wb_data_o(wb_data16), .illegal_o(illegal16)
  );

  // External ALU model, optionally overridden to seed register values.
  always_comb begin
    if (ovr_en)                result32 = ovr_val;
    else if (op32 == ALU_SUB)  result32 = src1_32 - src2_32;
    else                       result32 = src1_32 + src2_32;
  end

  always_comb begin
    if (ovr_en)                result16 = ovr_val;
    else if (op16 == ALU_SUB)  result16 = src1_16 - src2_16;
    else                       result16 = src1_16 + src2_16;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one legal instruction and checks the full 3-cycle sequence.
  // instr_valid_i stays high through EXEC to show it is ignored there.
  task automatic applyStimulus(input string tag, input logic [31:0] instr,
                               input logic oe, input logic [31:0] ov,
                               input logic [31:0] exp_op, input logic [31:0] exp_s1,
                               input logic [31:0] exp_s2, input logic [4:0] exp_rd,
                               input logic [31:0] exp_data);
    @(negedge clk_i);
    checkOutput({tag, " ready"}, 32'(ready32), 32'd1);
    instr_i = instr;
    instr_valid_i = 1'b1;
    ovr_en = oe;
    ovr_val = ov;
    @(posedge clk_i); #1;
    checkOutput({tag, " op"}, 32'(op32), exp_op);
    checkOutput({tag, " src1"}, src1_32, exp_s1);
    checkOutput({tag, " src2"}, src2_32, exp_s2);
    checkOutput({tag, " exec wb_valid"}, 32'(wb_valid32), 32'd0);
    checkOutput({tag, " exec ready"}, 32'(ready32), 32'd0);
    checkOutput({tag, " illegal"}, 32'(illegal32), 32'd0);
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    ovr_en = 1'b0;
    checkOutput({tag, " wb_valid"}, 32'(wb_valid32), 32'd1);
    checkOutput({tag, " wb_rd"}, 32'(wb_rd32), 32'(exp_rd));
    checkOutput({tag, " wb_data"}, wb_data32, exp_data);
    @(posedge clk_i); #1;
    checkOutput({tag, " post wb_valid"}, 32'(wb_valid32), 32'd0);
    checkOutput({tag, " post ready"}, 32'(ready32), 32'd1);
  endtask

  task automatic loadReg(input logic [4:0] idx, input logic [31:0] val);
    applyStimulus("load", enc_r(7'd0, 5'd0, 5'd0, idx), 1'b1, val,
                  32'd0, 32'd0, 32'd0, idx, val);
  endtask

  task automatic applyIllegal(input string tag, input logic [31:0] instr);
    @(negedge clk_i);
    instr_i = instr;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    checkOutput({tag, " illegal"}, 32'(illegal32), 32'd1);
    checkOutput({tag, " wb_valid"}, 32'(wb_valid32), 32'd0);
    checkOutput({tag, " ready"}, 32'(ready32), 32'd1);
    @(posedge clk_i); #1;
    checkOutput({tag, " illegal end"}, 32'(illegal32), 32'd0);
    checkOutput({tag, " no wb"}, 32'(wb_valid32), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ready"}, 32'(ready32), 32'd0);
    checkOutput({tag, " op"}, 32'(op32), 32'd0);
    checkOutput({tag, " src1"}, src1_32, 32'd0);
    checkOutput({tag, " src2"}, src2_32, 32'd0);
    checkOutput({tag, " wb_valid"}, 32'(wb_valid32), 32'd0);
    checkOutput({tag, " wb_rd"}, 32'(wb_rd32), 32'd0);
    checkOutput({tag, " wb_data"}, wb_data32, 32'd0);
    checkOutput({tag, " illegal"}, 32'(illegal32), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    instr_i = 32'd0;
    instr_valid_i = 1'b0;
    ovr_en = 1'b0;
    ovr_val = 32'd0;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    checkResetValues("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

`ifdef ALU_ISSUE_ADDI_EN
    applyStimulus("addi x1", enc_i(12'd5, 5'd0, 5'd1), 1'b0, 32'd0, 32'd0, 32'd0, 32'd5, 5'd1, 32'd5);
    applyStimulus("addi x2", enc_i(12'd3, 5'd0, 5'd2), 1'b0, 32'd0, 32'd0, 32'd0, 32'd3, 5'd2, 32'd3);
`else
    applyIllegal("addi off", enc_i(12'd5, 5'd0, 5'd1));
    applyStimulus("x1 kept", enc_r(7'd0, 5'd0, 5'd1, 5'd10), 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd10, 32'd0);
    loadReg(5'd1, 32'd5);
    loadReg(5'd2, 32'd3);
`endif
    applyStimulus("add x3", enc_r(7'd0, 5'd2, 5'd1, 5'd3), 1'b0, 32'd0, 32'd0, 32'd5, 32'd3, 5'd3, 32'd8);

    loadReg(5'd1, 32'd3);
    loadReg(5'd2, 32'd5);
    applyStimulus("sub x4", enc_r(7'b0100000, 5'd2, 5'd1, 5'd4), 1'b0, 32'd0, 32'd1, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE);

    loadReg(5'd1, 32'hFFFF_FFFF);
    loadReg(5'd2, 32'd1);
    applyStimulus("add wrap", enc_r(7'd0, 5'd2, 5'd1, 5'd5), 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0);
`ifdef ALU_ISSUE_ADDI_EN
    applyStimulus("addi wrap", enc_i(12'd1, 5'd1, 5'd5), 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0);
    applyStimulus("addi neg", enc_i(12'hFFF, 5'd0, 5'd6), 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
    applyStimulus("addi x0", enc_i(12'd7, 5'd0, 5'd0), 1'b0, 32'd0, 32'd0, 32'd0, 32'd7, 5'd0, 32'd7);
`else
    loadReg(5'd0, 32'd7);
`endif
    applyStimulus("add x6 x0", enc_r(7'd0, 5'd0, 5'd0, 5'd6), 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd6, 32'd0);

    applyIllegal("funct3", 32'h0000_2033);
    applyIllegal("funct7", 32'h0200_0033);
    applyIllegal("lui", 32'h0000_00B7);
    applyStimulus("x4 intact", enc_r(7'd0, 5'd0, 5'd4, 5'd12), 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0, 5'd12, 32'hFFFF_FFFE);

    // rd=20 is legal for 32 registers but out of range for 16.
    loadReg(5'd1, 32'd10);
    loadReg(5'd2, 32'd20);
    @(negedge clk_i);
    instr_i = enc_r(7'd0, 5'd2, 5'd1, 5'd20);
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    checkOutput("rv32e illegal", 32'(illegal16), 32'd1);
    checkOutput("rv32e ready", 32'(ready16), 32'd1);
    checkOutput("rv32i busy", 32'(ready32), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("rv32e illegal end", 32'(illegal16), 32'd0);
    checkOutput("rv32e no wb", 32'(wb_valid16), 32'd0);
    checkOutput("rv32i x20 wb_valid", 32'(wb_valid32), 32'd1);
    checkOutput("rv32i x20 wb_rd", 32'(wb_rd32), 32'd20);
    checkOutput("rv32i x20 wb_data", wb_data32, 32'd30);
    @(posedge clk_i); #1;
    checkOutput("rv32e still no wb", 32'(wb_valid16), 32'd0);
    checkOutput("rv32i ready again", 32'(ready32), 32'd1);

    // Reset while ADD x7,x1,x2 is in EXEC.
    @(negedge clk_i);
    instr_i = enc_r(7'd0, 5'd2, 5'd1, 5'd7);
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    checkOutput("abort src1", src1_32, 32'd10);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkResetValues("abort");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("abort no wb", 32'(wb_valid32), 32'd0);
    applyStimulus("x7 cleared", enc_r(7'd0, 5'd1, 5'd7, 5'd11), 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd11, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
